// File: rtl/pipeline_control.sv
// rtl/pipeline_control.sv - control decode, control pipeline and hazard unit for the 5-stage core
//
// Decodes the Decode-stage instruction, carries its control bits through the
// E, M and W control registers alongside the datapath, resolves branch/jump in
// Execute and produces stall, flush and forwarding selects.
//
// Build option: PIPECTRL_FWD_EN
//   defined   - forwarding from M/W, stall only on load-use
//   undefined - forwarding disabled (selects tied to 00), stall on any E/M
//               producer match
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   opD, funct3D, funct7b5D          instruction fields in Decode
//   Rs1D, Rs2D                       source registers in Decode
//   Rs1E, Rs2E, RdE, RdM, RdW        register fields of later stages
//   ZeroE                            ALU zero flag
//   ImmSrcD, IllegalD                combinational decode outputs
//   ALUControlE, ALUSrcE, PCSrcE     Execute-stage controls
//   MemWriteM                        Memory-stage write enable
//   RegWriteW, ResultSrcW            Writeback-stage controls
//   StallF, StallD, FlushD, FlushE   hazard controls
//   ForwardAE, ForwardBE             ALU operand forwarding selects
module pipeline_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opD,
    input  logic [2:0] funct3D,
    input  logic       funct7b5D,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       ZeroE,
    output logic [2:0] ImmSrcD,
    output logic [2:0] ALUControlE,
    output logic       ALUSrcE,
    output logic       PCSrcE,
    output logic       MemWriteM,
    output logic       RegWriteW,
    output logic [1:0] ResultSrcW,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       FlushE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       IllegalD
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // alu_op_d: 00 force add, 01 force sub, 10 select by funct3
    logic       reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
    logic [1:0] result_src_d, alu_op_d;
    logic [2:0] alu_control_d;

    logic       reg_write_e, mem_write_e, jump_e, branch_e;
    logic [1:0] result_src_e;
    logic       reg_write_m;
    logic [1:0] result_src_m;
    logic       stall;

    always_comb begin
        reg_write_d  = 1'b0;
        mem_write_d  = 1'b0;
        jump_d       = 1'b0;
        branch_d     = 1'b0;
        alu_src_d    = 1'b0;
        result_src_d = 2'b00;
        alu_op_d     = 2'b00;
        ImmSrcD      = 3'b000;
        IllegalD     = 1'b0;
        case (opD)
            OP_LW: begin
                reg_write_d  = 1'b1;
                alu_src_d    = 1'b1;
                result_src_d = 2'b01;
            end
            OP_IALU: begin
                reg_write_d = 1'b1;
                alu_src_d   = 1'b1;
                alu_op_d    = 2'b10;
            end
            OP_SW: begin
                mem_write_d = 1'b1;
                alu_src_d   = 1'b1;
                ImmSrcD     = 3'b001;
            end
            OP_R: begin
                reg_write_d = 1'b1;
                alu_op_d    = 2'b10;
            end
            OP_BEQ: begin
                branch_d = 1'b1;
                alu_op_d = 2'b01;
                ImmSrcD  = 3'b010;
            end
            OP_JAL: begin
                reg_write_d  = 1'b1;
                jump_d       = 1'b1;
                result_src_d = 2'b10;
                ImmSrcD      = 3'b011;
            end
            default: IllegalD = 1'b1;
        endcase
    end

    always_comb begin
        alu_control_d = ALU_ADD;
        case (alu_op_d)
            2'b01: alu_control_d = ALU_SUB;
            2'b10: begin
                case (funct3D)
                    // funct7b5 on an I-ALU is immediate bits, so only R-type may subtract
                    3'b000:  alu_control_d = (opD == OP_R && funct7b5D) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_d = ALU_SLT;
                    3'b110:  alu_control_d = ALU_OR;
                    3'b111:  alu_control_d = ALU_AND;
                    default: alu_control_d = ALU_ADD;
                endcase
            end
            default: alu_control_d = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            reg_write_e  <= 1'b0;
            result_src_e <= 2'b00;
            mem_write_e  <= 1'b0;
            jump_e       <= 1'b0;
            branch_e     <= 1'b0;
            ALUControlE  <= 3'b000;
            ALUSrcE      <= 1'b0;
        end else begin
            reg_write_e  <= reg_write_d;
            result_src_e <= result_src_d;
            mem_write_e  <= mem_write_d;
            jump_e       <= jump_d;
            branch_e     <= branch_d;
            ALUControlE  <= alu_control_d;
            ALUSrcE      <= alu_src_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_m  <= 1'b0;
            result_src_m <= 2'b00;
            MemWriteM    <= 1'b0;
            RegWriteW    <= 1'b0;
            ResultSrcW   <= 2'b00;
        end else begin
            reg_write_m  <= reg_write_e;
            result_src_m <= result_src_e;
            MemWriteM    <= mem_write_e;
            RegWriteW    <= reg_write_m;
            ResultSrcW   <= result_src_m;
        end
    end

    assign PCSrcE = jump_e | (branch_e & ZeroE);

`ifdef PIPECTRL_FWD_EN
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                           input logic rw_m, input logic [4:0] rd_w,
                                           input logic rw_w);
        if (rs != 5'd0 && rs == rd_m && rw_m)
            return 2'b10;
        else if (rs != 5'd0 && rs == rd_w && rw_w)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Only a load in E cannot be covered by forwarding
    assign stall = (result_src_e == 2'b01) && (RdE != 5'd0) &&
                   ((Rs1D == RdE) || (Rs2D == RdE));

    assign ForwardAE = fwd_sel(Rs1E, RdM, reg_write_m, RdW, RegWriteW);
    assign ForwardBE = fwd_sel(Rs2E, RdM, reg_write_m, RdW, RegWriteW);
`else
    function automatic logic pending(input logic [4:0] rs, input logic [4:0] rd_e,
                                     input logic rw_e, input logic [4:0] rd_m,
                                     input logic rw_m);
        return (rs != 5'd0) && ((rs == rd_e && rw_e) || (rs == rd_m && rw_m));
    endfunction

    // Without forwarding, wait until the producer reaches W; the register
    // file writes before it reads in that cycle, so W needs no stall.
    assign stall = pending(Rs1D, RdE, reg_write_e, RdM, reg_write_m) ||
                   pending(Rs2D, RdE, reg_write_e, RdM, reg_write_m);

    assign ForwardAE = 2'b00;
    assign ForwardBE = 2'b00;

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{Rs1E, Rs2E, RdW};
`endif

    assign StallF = stall;
    assign StallD = stall;
    assign FlushD = PCSrcE;
    assign FlushE = stall | PCSrcE;

endmodule

// File: tb/tb_pipeline_control.sv
// tb/tb_pipeline_control.sv - self-checking bench for pipeline_control
module tb_pipeline_control;

    logic       clk, reset;
    logic [6:0] opD;
    logic [2:0] funct3D;
    logic       funct7b5D;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       ZeroE;
    logic [2:0] ImmSrcD, ALUControlE;
    logic       ALUSrcE, PCSrcE, MemWriteM, RegWriteW;
    logic [1:0] ResultSrcW;
    logic       StallF, StallD, FlushD, FlushE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       IllegalD;

    pipeline_control dut (
        .clk(clk), .reset(reset), .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ZeroE(ZeroE), .ImmSrcD(ImmSrcD), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .PCSrcE(PCSrcE), .MemWriteM(MemWriteM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .IllegalD(IllegalD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [4:0] rs1, rs2, rd;
    } instr_t;

    typedef struct packed {
        logic       regw;
        logic [1:0] res;
        logic       memw, jump, branch;
        logic [2:0] alu;
        logic       alusrc;
        logic [2:0] imm;
        logic       ill;
    } ctl_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [2:0] imm;
        logic       ill;
        logic [2:0] alu;
        logic       alusrc;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int cnt_stall, cnt_fa2, cnt_fa1, cnt_fb1, cnt_pcs, cnt_fd, cnt_fe, cnt_res2, cnt_ill, cnt_regw, cnt_memw;

    instr_t prog[$];
    instr_t sd, se, sm, sw;
    localparam instr_t BUB = '0;

    function automatic instr_t mk(logic [6:0] op, logic [2:0] f3, logic f7,
                                  logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd);
        instr_t i;
        i.op = op; i.f3 = f3; i.f7 = f7; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
        return i;
    endfunction

    function automatic instr_t nop();
        return mk(7'b0010011, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0);
    endfunction

    function automatic instr_t fetch();
        if (prog.size() > 0) return prog.pop_front();
        return nop();
    endfunction

    // Operation chosen from funct3; sub only when the instruction asks for it
    function automatic logic [2:0] alu_of(logic [2:0] f3, logic want_sub);
        case (f3)
            3'b000:  return want_sub ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic ctl_t dec(instr_t i);
        ctl_t c = '0;
        case (i.op)
            7'b0000011: begin c.regw = 1; c.res = 2'b01; c.alusrc = 1; end
            7'b0010011: begin c.regw = 1; c.alusrc = 1; c.alu = alu_of(i.f3, 1'b0); end
            7'b0100011: begin c.memw = 1; c.alusrc = 1; c.imm = 3'b001; end
            7'b0110011: begin c.regw = 1; c.alu = alu_of(i.f3, i.f7); end
            7'b1100011: begin c.branch = 1; c.alu = 3'b001; c.imm = 3'b010; end
            7'b1101111: begin c.regw = 1; c.res = 2'b10; c.jump = 1; c.imm = 3'b011; end
            default:    c.ill = 1;
        endcase
        return c;
    endfunction

    // Forward source for one operand: newest producer wins, x0 never matches
    function automatic logic [1:0] fwd(logic [4:0] rs);
        if (rs == 0) return 2'b00;
        if (rs == sm.rd && dec(sm).regw) return 2'b10;
        if (rs == sw.rd && dec(sw).regw) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic busy(logic [4:0] rs);
        return rs != 0 && ((rs == se.rd && dec(se).regw) || (rs == sm.rd && dec(sm).regw));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr_counts();
        cnt_stall = 0; cnt_fa2 = 0; cnt_fa1 = 0; cnt_fb1 = 0; cnt_pcs = 0; cnt_fd = 0;
        cnt_fe = 0; cnt_res2 = 0; cnt_ill = 0; cnt_regw = 0; cnt_memw = 0;
    endtask

    // One clock: drive the stage contents, check every output, advance the model
    task automatic step(input logic rst, input logic z);
        ctl_t cd, ce, cm, cw;
        logic stall, pcs;
        logic [1:0] fa, fb;
        instr_t nx;
        @(negedge clk);
        reset = rst; ZeroE = z;
        opD = sd.op; funct3D = sd.f3; funct7b5D = sd.f7; Rs1D = sd.rs1; Rs2D = sd.rs2;
        Rs1E = se.rs1; Rs2E = se.rs2; RdE = se.rd; RdM = sm.rd; RdW = sw.rd;
        #1;
        cd = dec(sd); ce = dec(se); cm = dec(sm); cw = dec(sw);
        pcs = ce.jump | (ce.branch & z);
`ifdef PIPECTRL_FWD_EN
        stall = ce.res == 2'b01 && se.rd != 0 && (sd.rs1 == se.rd || sd.rs2 == se.rd);
        fa = fwd(se.rs1);
        fb = fwd(se.rs2);
`else
        stall = busy(sd.rs1) || busy(sd.rs2);
        fa = 2'b00;
        fb = 2'b00;
`endif
        chk("ImmSrcD", ImmSrcD, cd.imm);
        chk("IllegalD", IllegalD, cd.ill);
        chk("ALUControlE", ALUControlE, ce.alu);
        chk("ALUSrcE", ALUSrcE, ce.alusrc);
        chk("PCSrcE", PCSrcE, pcs);
        chk("MemWriteM", MemWriteM, cm.memw);
        chk("RegWriteW", RegWriteW, cw.regw);
        chk("ResultSrcW", ResultSrcW, cw.res);
        chk("StallF", StallF, stall);
        chk("StallD", StallD, stall);
        chk("FlushD", FlushD, pcs);
        chk("FlushE", FlushE, stall | pcs);
        chk("ForwardAE", ForwardAE, fa);
        chk("ForwardBE", ForwardBE, fb);
        cnt_stall += int'(StallF);
        cnt_fa2 += int'(ForwardAE == 2'b10);
        cnt_fa1 += int'(ForwardAE == 2'b01);
        cnt_fb1 += int'(ForwardBE == 2'b01);
        cnt_pcs += int'(PCSrcE);
        cnt_fd += int'(FlushD);
        cnt_fe += int'(FlushE);
        cnt_res2 += int'(ResultSrcW == 2'b10);
        cnt_ill += int'(IllegalD);
        cnt_regw += int'(RegWriteW);
        cnt_memw += int'(MemWriteM);
        @(posedge clk);
        if (rst) begin
            se = BUB; sm = BUB; sw = BUB;
            sd = fetch();
        end else begin
            sw = sm; sm = se;
            se = (stall | pcs) ? BUB : sd;
            if (!stall) begin
                nx = fetch();
                sd = pcs ? BUB : nx;
            end
        end
    endtask

    task automatic run(input int n, input logic z);
        for (int k = 0; k < n; k++) step(1'b0, z);
    endtask

`ifdef PIPECTRL_FWD_EN
    localparam int EXP_A_STALL = 1 - 1, EXP_A_FA2 = 1, EXP_A_FA1 = 1;
    localparam int EXP_B_STALL = 1, EXP_B_FA1 = 1;
`else
    localparam int EXP_A_STALL = 2, EXP_A_FA2 = 0, EXP_A_FA1 = 0;
    localparam int EXP_B_STALL = 2, EXP_B_FA1 = 0;
`endif

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{7'b0000011, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 1'b1};
        tbl[1]  = '{7'b0010011, 3'b000, 1'b1, 3'b000, 1'b0, 3'b000, 1'b1};
        tbl[2]  = '{7'b0010011, 3'b010, 1'b0, 3'b000, 1'b0, 3'b101, 1'b1};
        tbl[3]  = '{7'b0010011, 3'b110, 1'b0, 3'b000, 1'b0, 3'b011, 1'b1};
        tbl[4]  = '{7'b0010011, 3'b111, 1'b0, 3'b000, 1'b0, 3'b010, 1'b1};
        tbl[5]  = '{7'b0010011, 3'b100, 1'b0, 3'b000, 1'b0, 3'b000, 1'b1};
        tbl[6]  = '{7'b0100011, 3'b010, 1'b0, 3'b001, 1'b0, 3'b000, 1'b1};
        tbl[7]  = '{7'b0110011, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0};
        tbl[8]  = '{7'b0110011, 3'b000, 1'b1, 3'b000, 1'b0, 3'b001, 1'b0};
        tbl[9]  = '{7'b0110011, 3'b010, 1'b1, 3'b000, 1'b0, 3'b101, 1'b0};
        tbl[10] = '{7'b0110011, 3'b110, 1'b0, 3'b000, 1'b0, 3'b011, 1'b0};
        tbl[11] = '{7'b0110011, 3'b111, 1'b0, 3'b000, 1'b0, 3'b010, 1'b0};
        tbl[12] = '{7'b0110011, 3'b001, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0};
        tbl[13] = '{7'b1100011, 3'b000, 1'b0, 3'b010, 1'b0, 3'b001, 1'b0};
        tbl[14] = '{7'b1101111, 3'b000, 1'b0, 3'b011, 1'b0, 3'b000, 1'b0};
        tbl[15] = '{7'b1111111, 3'b000, 1'b0, 3'b000, 1'b1, 3'b000, 1'b0};

        reset = 1'b1; ZeroE = 1'b0; opD = '0; funct3D = '0; funct7b5D = 1'b0;
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        sd = nop(); se = BUB; sm = BUB; sw = BUB;
        clr_counts();
        @(posedge clk);

        // Reset held two cycles with an R-type add waiting in Decode
        prog.push_back(mk(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3));
        prog.push_back(mk(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3));
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b0);
            #1;
            chk("rst ALUControlE", ALUControlE, 3'b000);
            chk("rst ALUSrcE", ALUSrcE, 1'b0);
            chk("rst PCSrcE", PCSrcE, 1'b0);
            chk("rst MemWriteM", MemWriteM, 1'b0);
            chk("rst RegWriteW", RegWriteW, 1'b0);
            chk("rst ResultSrcW", ResultSrcW, 2'b00);
        end
        step(1'b0, 1'b0);
        #1 chk("post-rst ALUControlE", ALUControlE, 3'b000);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        #1 chk("post-rst RegWriteW", RegWriteW, 1'b1);
        run(3, 1'b0);

        // Decode table: instruction, then two bubbles so each entry lands alone
        foreach (tbl[i]) begin
            prog.push_back(mk(tbl[i].op, tbl[i].f3, tbl[i].f7, 5'd0, 5'd0, 5'd0));
            prog.push_back(BUB);
            prog.push_back(BUB);
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
            #1;
            chk($sformatf("tbl%0d ImmSrcD", i), ImmSrcD, tbl[i].imm);
            chk($sformatf("tbl%0d IllegalD", i), IllegalD, tbl[i].ill);
            chk($sformatf("tbl%0d ALUControlE", i), ALUControlE, tbl[i].alu);
            chk($sformatf("tbl%0d ALUSrcE", i), ALUSrcE, tbl[i].alusrc);
            step(1'b0, 1'b0);
        end
        run(4, 1'b0);

        // add x3,x1,x2 ; sub x4,x3,x1 ; or x5,x3,x0
        clr_counts();
        prog.push_back(mk(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3));
        prog.push_back(mk(7'b0110011, 3'b000, 1'b1, 5'd3, 5'd1, 5'd4));
        prog.push_back(mk(7'b0110011, 3'b110, 1'b0, 5'd3, 5'd0, 5'd5));
        run(9, 1'b0);
        chk("addsub stalls", cnt_stall, EXP_A_STALL);
        chk("addsub fwdA=10", cnt_fa2, EXP_A_FA2);
        chk("addsub fwdA=01", cnt_fa1, EXP_A_FA1);

        // lw x5,0(x0) ; add x6,x5,x5
        clr_counts();
        prog.push_back(mk(7'b0000011, 3'b010, 1'b0, 5'd0, 5'd0, 5'd5));
        prog.push_back(mk(7'b0110011, 3'b000, 1'b0, 5'd5, 5'd5, 5'd6));
        run(8, 1'b0);
        chk("lwuse stalls", cnt_stall, EXP_B_STALL);
        chk("lwuse fwdA=01", cnt_fa1, EXP_B_FA1);
        chk("lwuse fwdB=01", cnt_fb1, EXP_B_FA1);

        // beq taken, then not taken
        clr_counts();
        prog.push_back(mk(7'b1100011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0));
        run(6, 1'b1);
        chk("beq taken PCSrcE", cnt_pcs, 1);
        chk("beq taken FlushD", cnt_fd, 1);
        chk("beq taken FlushE", cnt_fe, 1);
        clr_counts();
        prog.push_back(mk(7'b1100011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0));
        run(6, 1'b0);
        chk("beq not-taken PCSrcE", cnt_pcs, 0);
        chk("beq not-taken FlushD", cnt_fd, 0);
        chk("beq not-taken FlushE", cnt_fe, 0);

        // jal x1
        clr_counts();
        prog.push_back(mk(7'b1101111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1));
        run(6, 1'b0);
        chk("jal PCSrcE", cnt_pcs, 1);
        chk("jal ResultSrcW=10", cnt_res2, 1);

        // Illegal opcode surrounded by bubbles: nothing may write
        for (int k = 0; k < 4; k++) prog.push_back(BUB);
        run(4, 1'b0);
        clr_counts();
        prog.push_back(mk(7'b1111111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd7));
        for (int k = 0; k < 4; k++) prog.push_back(BUB);
        run(5, 1'b0);
        chk("illegal IllegalD cycles", cnt_ill, 5);
        chk("illegal RegWriteW", cnt_regw, 0);
        chk("illegal MemWriteM", cnt_memw, 0);

        // Random instruction stream with occasional mid-flight resets
        for (int n = 0; n < 3000; n++) begin
            logic [6:0] op;
            case ($urandom_range(0, 6))
                0: op = 7'b0000011;
                1: op = 7'b0010011;
                2: op = 7'b0100011;
                3: op = 7'b0110011;
                4: op = 7'b1100011;
                5: op = 7'b1101111;
                default: op = 7'($urandom);
            endcase
            prog.push_back(mk(op, 3'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))));
            step($urandom_range(0, 63) == 0, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
